// File: rtl/multdiv_ctrl.sv
// Issue/writeback controller between execute and the multiplier/divider units.
// Optional fast divide-by-zero path: define MULTDIV_DIV0_FAST_EN.
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT    = 40,
  parameter int unsigned STATUS_REG = 30,
  parameter int unsigned EXC_MUL    = 4,
  parameter int unsigned EXC_DIV    = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_rd,
  input  logic        op_flush,
  output logic        op_ready,
  output logic        stall,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] mult_result,
  input  logic        mult_exception,
  input  logic        mult_rdy,
  input  logic [31:0] div_result,
  input  logic        div_exception,
  input  logic        div_rdy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [RW-1:0] STATUS_RD = RW'(STATUS_REG);
  localparam logic [DW-1:0] EXC_MUL_W = DW'(EXC_MUL);
  localparam logic [DW-1:0] EXC_DIV_W = DW'(EXC_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] unit_a_q, unit_a_d, unit_b_q, unit_b_d;
  logic          is_div_q, is_div_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ctrl_mult_q, ctrl_mult_d, ctrl_div_q, ctrl_div_d;
  logic          wb_valid_q, wb_valid_d;
  logic [RW-1:0] wb_rd_q, wb_rd_d;
  logic [DW-1:0] wb_data_q, wb_data_d;

  logic          div0_fast;
  logic          sel_rdy, sel_exc, fin_exc;
  logic [DW-1:0] sel_res;

`ifdef MULTDIV_DIV0_FAST_EN
  assign div0_fast = op_is_div && (op_b == '0);
`else
  assign div0_fast = 1'b0;
`endif

  // Only the unit that was started is listened to.
  assign sel_rdy = is_div_q ? div_rdy       : mult_rdy;
  assign sel_exc = is_div_q ? div_exception : mult_exception;
  assign sel_res = is_div_q ? div_result    : mult_result;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      unit_a_q    <= '0;
      unit_b_q    <= '0;
      is_div_q    <= 1'b0;
      rd_q        <= '0;
      cnt_q       <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      unit_a_q    <= unit_a_d;
      unit_b_q    <= unit_b_d;
      is_div_q    <= is_div_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    unit_a_d    = unit_a_q;
    unit_b_d    = unit_b_q;
    is_div_d    = is_div_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    ctrl_mult_d = 1'b0;
    ctrl_div_d  = 1'b0;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    fin_exc     = 1'b0;
    op_ready    = 1'b0;
    stall       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid && !op_flush) begin
          stall    = 1'b1;
          unit_a_d = op_a;
          unit_b_d = op_b;
          is_div_d = op_is_div;
          rd_d     = op_rd;
          if (div0_fast) begin
            state_d    = S_DONE;
            wb_valid_d = 1'b1;
            wb_rd_d    = STATUS_RD;
            wb_data_d  = EXC_DIV_W;
          end else begin
            state_d     = S_START;
            ctrl_mult_d = !op_is_div;
            ctrl_div_d  = op_is_div;
          end
        end
      end
      S_START: begin
        stall   = 1'b1;
        cnt_d   = '0;
        state_d = op_flush ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        stall = 1'b1;
        if (op_flush) begin
          state_d = S_IDLE;
        end else if (sel_rdy || (cnt_q == CNT_LAST)) begin
          // A missing rdy at the last count is a forced exception.
          state_d = S_DONE;
          fin_exc = !sel_rdy || sel_exc;
          if (fin_exc) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = STATUS_RD;
            wb_data_d  = is_div_q ? EXC_DIV_W : EXC_MUL_W;
          end else begin
            wb_valid_d = (rd_q != '0);
            wb_rd_d    = rd_q;
            wb_data_d  = sel_res;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign unit_a    = unit_a_q;
  assign unit_b    = unit_b_q;
  assign ctrl_MULT = ctrl_mult_q;
  assign ctrl_DIV  = ctrl_div_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: a cycle-level transaction model predicts every
// output each cycle; literal checks pin latency and writeback values per scenario.
module tb_multdiv_ctrl;

  localparam int TIMEOUT = 40;

  logic        clock, reset;
  logic        op_valid, op_is_div, op_flush;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic        op_ready, stall, ctrl_MULT, ctrl_DIV;
  logic [31:0] unit_a, unit_b;
  logic [31:0] mult_result, div_result;
  logic        mult_exception, mult_rdy, div_exception, div_rdy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  multdiv_ctrl dut (
    .clock(clock), .reset(reset),
    .op_valid(op_valid), .op_is_div(op_is_div), .op_a(op_a), .op_b(op_b),
    .op_rd(op_rd), .op_flush(op_flush), .op_ready(op_ready), .stall(stall),
    .unit_a(unit_a), .unit_b(unit_b), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .mult_result(mult_result), .mult_exception(mult_exception), .mult_rdy(mult_rdy),
    .div_result(div_result), .div_exception(div_exception), .div_rdy(div_rdy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Model of the current transaction, in absolute cycle numbers (-100 = none).
  int          m_A = -100, m_P = -100, m_R = -100, m_D = -100, m_F = -100;
  int          m_E = -100, m_S = -100, m_blk = -100;
  bit          m_div, m_wb_en;
  logic [4:0]  m_wrd;
  logic [31:0] m_wdat;
  logic [31:0] m_ua = '0, m_ub = '0, m_ua_old = '0, m_ub_old = '0;
  bit          cmp_en = 1'b0;

  // Stimulus of the current transaction.
  bit          s_div, s_exc, s_noise;
  logic [31:0] s_a, s_b, s_res;
  logic [4:0]  s_rd;

  // Observed-event recorders for the literal checks.
  int n_pm = 0, n_pd = 0, n_wb = 0, wb_cyc = 0, p_cyc = 0;
  logic [31:0] wb_dat = '0;
  logic [4:0]  wb_r = '0;

  always @(negedge clock) begin
    if (reset && cmp_en) begin
      chk("op_ready", 32'(op_ready), 32'(!(cyc > m_A && cyc <= m_E)));
      if (cyc != m_blk)
        chk("stall", 32'(stall), 32'(cyc >= m_A && cyc <= m_S));
      chk("ctrl_MULT", 32'(ctrl_MULT), 32'(cyc == m_P && !m_div));
      chk("ctrl_DIV", 32'(ctrl_DIV), 32'(cyc == m_P && m_div));
      chk("wb_valid", 32'(wb_valid), 32'(cyc == m_D && m_wb_en));
      if (cyc == m_D && m_wb_en) begin
        chk("wb_rd", 32'(wb_rd), 32'(m_wrd));
        chk("wb_data", wb_data, m_wdat);
      end
      chk("unit_a", unit_a, (cyc > m_A) ? m_ua : m_ua_old);
      chk("unit_b", unit_b, (cyc > m_A) ? m_ub : m_ub_old);
      if (ctrl_MULT) n_pm++;
      if (ctrl_DIV) n_pd++;
      if (ctrl_MULT || ctrl_DIV) p_cyc = cyc;
      if (wb_valid) begin
        n_wb++;
        wb_cyc = cyc;
        wb_dat = wb_data;
        wb_r   = wb_rd;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    op_valid = 0; op_is_div = 0; op_a = '0; op_b = '0; op_rd = '0; op_flush = 0;
    mult_result = '0; mult_exception = 0; mult_rdy = 0;
    div_result = '0; div_exception = 0; div_rdy = 0;
  endtask

  // lat: cycles from the start pulse to rdy (<0: never). flush_after: cycles from START.
  task automatic setup_op(input bit div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input logic [31:0] res,
                          input bit exc, input int flush_after, input bit noise);
    bit fast, ex;
    fast = 1'b0;
`ifdef MULTDIV_DIV0_FAST_EN
    fast = div && (b == '0);
`endif
    s_div = div; s_a = a; s_b = b; s_rd = rd; s_res = res; s_exc = exc; s_noise = noise;
    m_A = cyc; m_ua_old = m_ua; m_ub_old = m_ub; m_ua = a; m_ub = b; m_div = div;
    m_P = fast ? -100 : m_A + 1;
    m_R = (lat < 0 || fast) ? -100 : m_A + 1 + lat;
    m_F = -100; m_D = -100; ex = 1'b0;
    if (fast) begin
      m_D = m_A + 1; ex = 1'b1;
    end else if (flush_after >= 0) begin
      m_F = m_A + 1 + flush_after;
    end else if (lat >= 1 && lat <= TIMEOUT + 1) begin
      m_D = m_R + 1; ex = exc;
    end else begin
      m_D = m_A + 1 + TIMEOUT + 2; ex = 1'b1;
    end
    m_E = (m_F >= 0) ? m_F : m_D;
    m_S = (m_F >= 0) ? m_F : m_D - 1;
    m_wrd   = ex ? 5'd30 : rd;
    m_wdat  = ex ? (div ? 32'd5 : 32'd4) : res;
    m_wb_en = (m_D >= 0) && (ex || rd != '0);
  endtask

  task automatic drive(input int c);
    bit busy_c;
    busy_c    = (c > m_A) && (c <= m_E);
    op_valid  = (c == m_A) || (s_noise && busy_c);
    op_is_div = s_div;
    op_a      = (c == m_A) ? s_a : $urandom();
    op_b      = (c == m_A) ? s_b : $urandom();
    op_rd     = (c == m_A) ? s_rd : 5'($urandom());
    op_flush  = (c == m_F);
    mult_rdy  = (!s_div && c == m_R) ||
                (s_noise && ((!s_div && c == m_A + 1) || (s_div && c >= m_A + 2)));
    div_rdy   = (s_div && c == m_R) ||
                (s_noise && ((s_div && c == m_A + 1) || (!s_div && c >= m_A + 2)));
    mult_result    = s_div ? $urandom() : s_res;
    div_result     = s_div ? s_res : $urandom();
    mult_exception = s_div ? s_noise : (c == m_R && s_exc);
    div_exception  = s_div ? (c == m_R && s_exc) : s_noise;
  endtask

  // Drives cycles m_A .. end-of-op, returning in the following IDLE cycle (or at stop).
  task automatic run_op(input int stop);
    int last;
    last = m_E + 1;
    for (int c = m_A; c < last && c < stop; c++) begin
      drive(c);
      tick();
    end
    drive_idle();
  endtask

  int b_pm, b_pd, b_wb;
  task automatic snap();
    b_pm = n_pm; b_pd = n_pd; b_wb = n_wb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive_idle();
    tick();
    tick();
    chk("rst_unit_a", unit_a, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    reset = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Multiply 7 * -3 with off-unit and START-cycle noise.
    snap();
    setup_op(1'b0, 32'd7, 32'hFFFFFFFD, 5'd5, 17, 32'hFFFFFFEB, 1'b0, -1, 1'b1);
    run_op(1 << 30);
    chk("t1_pulses", 32'(n_pm - b_pm), 32'd1);
    chk("t1_div_pulses", 32'(n_pd - b_pd), 32'd0);
    chk("t1_wb_count", 32'(n_wb - b_wb), 32'd1);
    chk("t1_latency", 32'(wb_cyc - m_A), 32'd19);
    chk("t1_wb_rd", 32'(wb_r), 32'd5);
    chk("t1_wb_data", wb_dat, 32'hFFFFFFEB);

    // Back-to-back multiply with exception.
    snap();
    setup_op(1'b0, 32'h00010000, 32'h00010000, 5'd9, 4, 32'd0, 1'b1, -1, 1'b0);
    run_op(1 << 30);
    chk("t2_wb_rd", 32'(wb_r), 32'd30);
    chk("t2_wb_data", wb_dat, 32'd4);

    // Divide timeout.
    snap();
    setup_op(1'b1, 32'd100, 32'd7, 5'd3, -1, 32'd0, 1'b0, -1, 1'b0);
    run_op(1 << 30);
    chk("t3_timeout_delay", 32'(wb_cyc - p_cyc), 32'd42);
    chk("t3_wb_rd", 32'(wb_r), 32'd30);
    chk("t3_wb_data", wb_dat, 32'd5);

    // Flush 3 cycles into BUSY, then a normal divide.
    snap();
    setup_op(1'b0, 32'd11, 32'd12, 5'd8, -1, 32'd0, 1'b0, 4, 1'b0);
    run_op(1 << 30);
    chk("t4_flush_wb", 32'(n_wb - b_wb), 32'd0);
    setup_op(1'b1, 32'd100, 32'd7, 5'd12, 6, 32'd14, 1'b0, -1, 1'b0);
    run_op(1 << 30);
    chk("t4_div_wb_rd", 32'(wb_r), 32'd12);
    chk("t4_div_wb_data", wb_dat, 32'd14);

    // Divide by zero.
    snap();
    setup_op(1'b1, 32'd10, 32'd0, 5'd7, 5, 32'd0, 1'b1, -1, 1'b0);
    run_op(1 << 30);
    chk("t5_wb_data", wb_dat, 32'd5);
    chk("t5_wb_rd", 32'(wb_r), 32'd30);
`ifdef MULTDIV_DIV0_FAST_EN
    chk("t5_div_pulses", 32'(n_pd - b_pd), 32'd0);
    chk("t5_latency", 32'(wb_cyc - m_A), 32'd1);
`else
    chk("t5_div_pulses", 32'(n_pd - b_pd), 32'd1);
    chk("t5_latency", 32'(wb_cyc - m_A), 32'd7);
`endif

    // Flush in IDLE blocks acceptance.
    snap();
    m_blk = cyc;
    op_valid = 1; op_flush = 1; op_a = 32'h55; op_b = 32'h66; op_rd = 5'd4;
    tick();
    drive_idle();
    tick();
    tick();
    chk("t6_blocked_pulses", 32'(n_pm - b_pm), 32'd0);

    // Asynchronous reset mid-BUSY.
    setup_op(1'b0, 32'd21, 32'd22, 5'd6, -1, 32'd0, 1'b0, -1, 1'b0);
    run_op(m_A + 5);
    cmp_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_unit_a", unit_a, 32'd0);
    chk("ar_unit_b", unit_b, 32'd0);
    chk("ar_wb_rd", 32'(wb_rd), 32'd0);
    chk("ar_wb_data", wb_data, 32'd0);
    chk("ar_wb_valid", 32'(wb_valid), 32'd0);
    chk("ar_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    chk("ar_stall", 32'(stall), 32'd0);
    chk("ar_op_ready", 32'(op_ready), 32'd1);
    m_A = -100; m_P = -100; m_R = -100; m_D = -100; m_F = -100; m_E = -100; m_S = -100;
    m_ua = '0; m_ub = '0; m_ua_old = '0; m_ub_old = '0;
    tick();
    reset = 1'b1;
    cmp_en = 1'b1;
    snap();
    mult_rdy = 1; mult_result = 32'd123;
    tick();
    drive_idle();
    tick();
    chk("ar_stray_wb", 32'(n_wb - b_wb), 32'd0);

    // Multiply to r0: completes silently.
    snap();
    setup_op(1'b0, 32'd3, 32'd4, 5'd0, 3, 32'd12, 1'b0, -1, 1'b0);
    run_op(1 << 30);
    chk("r0_wb_count", 32'(n_wb - b_wb), 32'd0);
    chk("r0_pulses", 32'(n_pm - b_pm), 32'd1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
